// File: rtl/division_pkg.sv
// Shared state encoding, default width and two's-complement helper for the divider.
// Latency: none (declarations only).
// Backpressure: none.
package division_pkg;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    ITERANDO = 2'd1,
    FIN      = 2'd2
  } estado_div_t;

  localparam int ANCHO_DEF = 4;

  // Negation on a fixed 32-bit carrier; callers truncate to their own width.
  function automatic logic [31:0] negar2c(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/paso_resta_restauradora.sv
// One restoring-division step: shift {R,Q} left, trial-subtract M, keep or restore.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module paso_resta_restauradora
  import division_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic [ANCHO-1:0] r_i,
  input  logic [ANCHO-1:0] q_i,
  input  logic [ANCHO-1:0] m_i,
  output logic [ANCHO-1:0] r_o,
  output logic [ANCHO-1:0] q_o
);

  logic [ANCHO:0] r_desp;
  logic [ANCHO:0] t;

  // Shifted partial remainder needs one extra bit; since R<M it always fits after the step.
  always_comb begin
    r_desp = {r_i, q_i[ANCHO-1]};
    t      = r_desp - {1'b0, m_i};
    if (t[ANCHO]) begin
      r_o = r_desp[ANCHO-1:0];
      q_o = {q_i[ANCHO-2:0], 1'b0};
    end else begin
      r_o = t[ANCHO-1:0];
      q_o = {q_i[ANCHO-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/subsistema_division.sv
// Iterative restoring divider (quotient + remainder); signed mode with DIVISION_CON_SIGNO_EN.
// Latency: strobe ANCHO+1 cycles after capture, 1 cycle for divide-by-zero.
// Backpressure: none; banderaValida is ignored while busy and is not queued.
module subsistema_division
  import division_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             reloj,
  input  logic             reinicio,
  input  logic [ANCHO-1:0] operandoA,
  input  logic [ANCHO-1:0] operandoB,
  input  logic             banderaValida,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] residuo,
  output logic             banderaError,
  output logic             banderaLista,
  output logic             banderaOcupado
);

  localparam int              CW     = $clog2(ANCHO + 1);
  localparam logic [CW-1:0]   ULTIMO = CW'(ANCHO - 1);

  estado_div_t       estado_q, estado_d;
  logic [ANCHO-1:0]  q_q, q_d;
  logic [ANCHO-1:0]  r_q, r_d;
  logic [ANCHO-1:0]  m_q, m_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cero_q, cero_d;
  logic              err_pend_q, err_pend_d;
  logic [ANCHO-1:0]  cociente_q, cociente_d;
  logic [ANCHO-1:0]  residuo_q, residuo_d;
  logic              error_q, error_d;
  logic              lista_q, lista_d;

  logic [ANCHO-1:0]  q_paso, r_paso;
  logic [ANCHO-1:0]  mag_a, mag_b;
  logic [ANCHO-1:0]  q_fin, r_fin;
  logic              desborde;

  paso_resta_restauradora #(.ANCHO(ANCHO)) u_paso (
    .r_i (r_q),
    .q_i (q_q),
    .m_i (m_q),
    .r_o (r_paso),
    .q_o (q_paso)
  );

`ifdef DIVISION_CON_SIGNO_EN
  logic signo_a_q, signo_a_d;
  logic signo_b_q, signo_b_d;

  function automatic logic [ANCHO-1:0] negar(input logic [ANCHO-1:0] v);
    return ANCHO'(negar2c(32'(v)));
  endfunction

  // Magnitudes enter the unsigned core; signs are reapplied on the way out.
  always_comb begin
    mag_a     = operandoA[ANCHO-1] ? negar(operandoA) : operandoA;
    mag_b     = operandoB[ANCHO-1] ? negar(operandoB) : operandoB;
    desborde  = (operandoA == {1'b1, {(ANCHO-1){1'b0}}}) && (&operandoB);
    signo_a_d = signo_a_q;
    signo_b_d = signo_b_q;
    if (estado_q == INACTIVO && banderaValida) begin
      signo_a_d = operandoA[ANCHO-1];
      signo_b_d = operandoB[ANCHO-1];
    end
    q_fin = (signo_a_q ^ signo_b_q) ? negar(q_q) : q_q;
    r_fin = signo_a_q ? negar(r_q) : r_q;
  end

  // Operand signs captured alongside the magnitudes.
  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      signo_a_q <= 1'b0;
      signo_b_q <= 1'b0;
    end else begin
      signo_a_q <= signo_a_d;
      signo_b_q <= signo_b_d;
    end
  end
`else
  // Unsigned build: operands feed the core directly and no overflow case exists.
  always_comb begin
    mag_a    = operandoA;
    mag_b    = operandoB;
    desborde = 1'b0;
    q_fin    = q_q;
    r_fin    = r_q;
  end
`endif

  // Next-state logic for the divider FSM and its datapath registers.
  always_comb begin
    estado_d   = estado_q;
    q_d        = q_q;
    r_d        = r_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    cero_d     = cero_q;
    err_pend_d = err_pend_q;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    error_d    = error_q;
    lista_d    = 1'b0;
    case (estado_q)
      INACTIVO: begin
        if (banderaValida) begin
          cnt_d = '0;
          m_d   = mag_b;
          if (operandoB == '0) begin
            // Divide-by-zero skips iteration; the raw dividend is the remainder.
            q_d        = '1;
            r_d        = operandoA;
            cero_d     = 1'b1;
            err_pend_d = 1'b1;
            estado_d   = FIN;
          end else begin
            q_d        = mag_a;
            r_d        = '0;
            cero_d     = 1'b0;
            err_pend_d = desborde;
            estado_d   = ITERANDO;
          end
        end
      end
      ITERANDO: begin
        q_d   = q_paso;
        r_d   = r_paso;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == ULTIMO) begin
          estado_d = FIN;
        end
      end
      FIN: begin
        cociente_d = cero_q ? q_q : q_fin;
        residuo_d  = cero_q ? r_q : r_fin;
        error_d    = err_pend_q;
        lista_d    = 1'b1;
        estado_d   = INACTIVO;
      end
      default: estado_d = INACTIVO;
    endcase
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      estado_q   <= INACTIVO;
      q_q        <= '0;
      r_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      cero_q     <= 1'b0;
      err_pend_q <= 1'b0;
      cociente_q <= '0;
      residuo_q  <= '0;
      error_q    <= 1'b0;
      lista_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      q_q        <= q_d;
      r_q        <= r_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      cero_q     <= cero_d;
      err_pend_q <= err_pend_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      error_q    <= error_d;
      lista_q    <= lista_d;
    end
  end

  assign cociente       = cociente_q;
  assign residuo        = residuo_q;
  assign banderaError   = error_q;
  assign banderaLista   = lista_q;
  assign banderaOcupado = (estado_q != INACTIVO);

endmodule
